lane_unstriping_n: RTL and testbench
====================================

// Module: lane_unstriping_n
// PURPOSE
//  Parametrised N-lane byte un-striping: recombines NUM_LANES independent lanes into one
//  ordered word stream. Each lane has its own deskew FIFO, so lanes may arrive skewed by up
//  to FIFO_DEPTH words. Output is strict round-robin lane 0,1,..,N-1,0,.. with valid/ready
//  backpressure. Single clock, so no clk_2f. Sits after the lane receivers, before the PCIe-side sink.
// PARAMETERS
//  NUM_LANES   2   lane count, legal 2..8
//  DATA_W      32  word width per lane and at output
//  FIFO_DEPTH  4   words per lane deskew FIFO, power of 2, >=2
// PORTS
//  clk        in   1                   single clock, rising edge
//  reset_L    in   1                   asynchronous, active-low reset
//  valid_in   in   NUM_LANES           bit i: lane_data word i valid this cycle
//  lane_data  in   NUM_LANES*DATA_W    lane i at [i*DATA_W +: DATA_W]
//  out_ready  in   1                   sink accepts data_out when valid_out&&out_ready
//  data_out   out  DATA_W              registered output word
//  valid_out  out  1                   registered output valid
//  lane_full  out  NUM_LANES           bit i: FIFO i holds FIFO_DEPTH words (combinational from count)
//  overflow   out  NUM_LANES           sticky bit i: lane i word dropped on full FIFO
// BEHAVIOUR
//  - Reset (reset_L=0, async): data_out=0, valid_out=0, overflow=0, all FIFOs empty
//    (lane_full=0), rd pointer rr_ptr=0. Reset mid-stream discards all buffered words.
//  - Write: lane i with valid_in[i]=1 pushes lane word i into FIFO i at the edge.
//    FIFO i full and not popped in the same cycle: word dropped, overflow[i] set, held until reset.
//    Full and popped in the same cycle: push accepted, count unchanged, no overflow.
//  - Load condition: load = (!valid_out || out_ready) && !empty[rr_ptr].
//    On load: data_out<=head(FIFO rr_ptr), valid_out<=1, pop FIFO rr_ptr,
//    rr_ptr<=(rr_ptr==LAST)?0:rr_ptr+1.
//    If (!valid_out||out_ready) and FIFO rr_ptr is empty: valid_out<=0, data_out holds,
//    rr_ptr holds. Strict order: no skipping of an empty lane.
//  - valid_out=1 && out_ready=0: data_out/valid_out hold stable; nothing popped.
//  - Latency: word written at edge k on the lane rr_ptr points to is on data_out after edge k+1
//    if the output is free. No read-through of the write in the same edge.
//  - Throughput: 1 word/cycle while every FIFO in turn is non-empty and out_ready=1.
//  - Pointers: per-FIFO wr/rd pointers with an extra wrap bit; wrap at FIFO_DEPTH.
//    Count = wr-rd, modulo 2*FIFO_DEPTH.
//  - Empty and simultaneous push on lane rr_ptr: load waits one cycle; the word is not bypassed.
// CONFIGURATION
//  UNSTRIPE_LANE_CNT_EN defined: extra input active_lanes [$clog2(NUM_LANES+1)-1:0].
//    LAST=active_lanes-1. Value 0 or >NUM_LANES is treated as NUM_LANES.
//    Sampled only when rr_ptr wraps to 0 (and at reset release); held in an internal register.
//    valid_in on lanes >= the active count is ignored: nothing stored, no overflow.
//    lane_full/overflow bits for those lanes stay 0.
//  Undefined: port absent; LAST=NUM_LANES-1; all lanes always active.
// TESTING
//  1 Reset: reset_L=0 with FIFOs holding data -> all outputs 0 asynchronously, before the next clk edge.
//  2 Order, N=2, ready=1: lane0 A0,A1 / lane1 B0,B1 (aligned) -> data_out A0,B0,A1,B1, no gaps, valid_out 1 cycle after first push.
//  3 Skew: lane1 words arrive 3 cycles after lane0 (N=4, DEPTH=4) -> output order still L0,L1,L2,L3, valid_out low during stall, no overflow.
//  4 Backpressure: out_ready=0 for 6 cycles with lane0 streaming 0x11111111.. -> data_out stable;
//    5th buffered push sets overflow[0]=1, lane_full[0]=1; data resumes in order.
//  5 Full+pop same cycle: FIFO0 full, out_ready=1, push 0xDEADBEEF -> accepted, overflow stays 0.
//  6 UNSTRIPE_LANE_CNT_EN, NUM_LANES=4, active_lanes=2 -> output alternates lane0/lane1 only;
//    lane3 writes ignored; change to 4 takes effect at the next wrap to 0.

Source files
------------

// File: rtl/lane_unstriping_n.sv
// lane_unstriping_n: per-lane deskew FIFOs drained in strict round-robin order into one word stream.
// Define UNSTRIPE_LANE_CNT_EN to add the active_lanes input, which limits how many lanes take part.
module lane_unstriping_n #(
    parameter int NUM_LANES  = 2,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic [NUM_LANES-1:0]           valid_in,
    input  logic [NUM_LANES*DATA_W-1:0]    lane_data,
`ifdef UNSTRIPE_LANE_CNT_EN
    input  logic [$clog2(NUM_LANES+1)-1:0] active_lanes,
`endif
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              data_out,
    output logic                           valid_out,
    output logic [NUM_LANES-1:0]           lane_full,
    output logic [NUM_LANES-1:0]           overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(NUM_LANES);

    logic [DATA_W-1:0]    head [NUM_LANES];
    logic [LW-1:0]        rr_ptr, last;
    logic [NUM_LANES-1:0] empty, full, active, push, pop;
    logic                 load;

`ifdef UNSTRIPE_LANE_CNT_EN
    localparam int CW = $clog2(NUM_LANES+1);
    logic [CW-1:0] cnt_q, cnt_in, cnt;
    logic          cnt_vld;
    assign cnt_in = (active_lanes == '0 || active_lanes > CW'(NUM_LANES)) ? CW'(NUM_LANES) : active_lanes;
    // Until the first post-reset edge the live input is used, so the count is taken at reset release.
    assign cnt    = cnt_vld ? cnt_q : cnt_in;
    assign last   = LW'(cnt - 1'b1);
    always_ff @(posedge clk or negedge reset_L)
        if (!reset_L) begin
            cnt_q   <= CW'(NUM_LANES);
            cnt_vld <= 1'b0;
        end else if (!cnt_vld || (load && rr_ptr == last)) begin
            cnt_q   <= cnt_in;
            cnt_vld <= 1'b1;
        end
`else
    assign last   = LW'(NUM_LANES - 1);
    assign active = '1;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [AW:0]       wr_ptr, rd_ptr, count;
`ifdef UNSTRIPE_LANE_CNT_EN
        assign active[i] = CW'(i) < cnt;
`endif
        assign count        = wr_ptr - rd_ptr;
        assign empty[i]     = count == '0;
        assign full[i]      = count == (AW+1)'(FIFO_DEPTH);
        assign pop[i]       = load && rr_ptr == LW'(i);
        assign push[i]      = valid_in[i] && active[i] && (!full[i] || pop[i]);
        assign lane_full[i] = full[i] && active[i];
        assign head[i]      = mem[rd_ptr[AW-1:0]];
        always_ff @(posedge clk or negedge reset_L)
            if (!reset_L) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[i]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[i]) rd_ptr <= rd_ptr + 1'b1;
            end
        always_ff @(posedge clk)
            if (push[i]) mem[wr_ptr[AW-1:0]] <= lane_data[i*DATA_W +: DATA_W];
    end

    // Strict order: an empty lane at rr_ptr stalls the output rather than being skipped.
    assign load = (!valid_out || out_ready) && !empty[rr_ptr];

    always_ff @(posedge clk or negedge reset_L)
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            rr_ptr    <= '0;
            overflow  <= '0;
        end else begin
            overflow <= overflow | (valid_in & active & ~push);
            if (load) begin
                data_out <= head[rr_ptr];
                rr_ptr   <= (rr_ptr == last) ? '0 : rr_ptr + 1'b1;
            end
            if (!valid_out || out_ready) valid_out <= load;
        end
endmodule

// File: tb/tb_lane_unstriping_n.sv
// tb_lane_unstriping_n: directed stimulus with per-lane expected-word queues drained in round-robin order.
module tb_lane_unstriping_n;
    localparam int N = 4;

    logic          clk = 1'b0, reset_L = 1'b0, out_ready = 1'b0;
    logic [N-1:0]  valid_in = '0;
    logic [N*32-1:0] lane_data = '0;
    logic [31:0]   data_out;
    logic          valid_out;
    logic [N-1:0]  lane_full, overflow;
`ifdef UNSTRIPE_LANE_CNT_EN
    logic [2:0]    active_lanes = 3'd4;
`endif
    int n_assert = 0, n_fail = 0, mrr = 0, mlast = N - 1;
    logic [31:0] lane_q [N][$];

    lane_unstriping_n #(.NUM_LANES(N), .DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .lane_data(lane_data),
`ifdef UNSTRIPE_LANE_CNT_EN
        .active_lanes(active_lanes),
`endif
        .out_ready(out_ready), .data_out(data_out), .valid_out(valid_out),
        .lane_full(lane_full), .overflow(overflow));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += lane_q[i].size();
        return s;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [31:0] base, input logic [N-1:0] keep);
        valid_in = v;
        for (int i = 0; i < N; i++) begin
            lane_data[i*32 +: 32] = base + 32'(i);
            if (keep[i]) lane_q[i].push_back(base + 32'(i));
        end
        tick();
        valid_in = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) lane_q[i].delete();
        mrr = 0;
    endtask

    // Every accepted output word must be the oldest outstanding word of the lane whose turn it is.
    always @(negedge clk)
        if (reset_L && valid_out && out_ready) begin
            check("lane_has_pending", 32'(lane_q[mrr].size() > 0), 1);
            if (lane_q[mrr].size() > 0) check("data_out_order", data_out, lane_q[mrr].pop_front());
            mrr = (mrr == mlast) ? 0 : mrr + 1;
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_lane_full", lane_full, 0);
        check("rst_overflow", overflow, 0);
        out_ready = 1'b1;
        reset_L = 1'b1;

        // Aligned order: output one cycle after the first push, then no gaps.
        drive('1, 32'hA000_0000, '1);
        check("t2_no_bypass", valid_out, 0);
        drive('1, 32'hA100_0000, '1);
        for (int k = 0; k < 8; k++) begin
            check("t2_stream_valid", valid_out, 1);
            tick();
        end
        check("t2_idle", valid_out, 0);
        check("t2_drained", pending(), 0);

        // Skew: lane1 three cycles late stalls the stream without reordering.
        drive(4'b1101, 32'hB000_0000, 4'b1101);
        tick();
        check("t3_lane0_out", valid_out, 1);
        tick();
        check("t3_stall", valid_out, 0);
        drive(4'b0010, 32'hB100_0000, 4'b0010);
        check("t3_no_bypass", valid_out, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_resume", valid_out, 1);
        end
        tick();
        check("t3_idle", valid_out, 0);
        check("t3_overflow", overflow, 0);

        // Backpressure: output holds, FIFO0 fills, sixth word is dropped.
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(4'b0001, 32'h1111_1111 * k, (k < 6) ? 4'b0001 : 4'b0000);
            if (k > 1) check("t4_hold", data_out, 32'h1111_1111);
            check("t4_valid", valid_out, (k > 1) ? 1 : 0);
            check("t4_full", lane_full, (k >= 5) ? 1 : 0);
            check("t4_overflow", overflow, (k == 6) ? 1 : 0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) drive(4'b1110, 32'hC000_0000 + 32'(k << 8), 4'b1110);
        tick(20);
        check("t4_drained", pending(), 0);
        check("t4_idle", valid_out, 0);
        check("t4_sticky", overflow, 1);

        // Asynchronous reset with data buffered.
        out_ready = 1'b0;
        drive('1, 32'hD000_0000, '0);
        tick();
        check("t1_pre_valid", valid_out, 1);
        #2 reset_L = 1'b0;
        #1;
        check("t1_async_valid", valid_out, 0);
        check("t1_async_data", data_out, 0);
        check("t1_async_overflow", overflow, 0);
        check("t1_async_full", lane_full, 0);
        clear_model();
        tick();
        reset_L = 1'b1;
        out_ready = 1'b1;
        tick(5);
        check("t1_discarded", valid_out, 0);

        // Full FIFO0 pushed while being popped: accepted, no overflow.
        drive('1, 32'hE000_0000, '1);
        for (int k = 1; k <= 4; k++) drive(4'b0001, 32'hE100_0000 + 32'(k << 4), 4'b0001);
        out_ready = 1'b0;
        check("t5_full", lane_full, 1);
        tick();
        check("t5_hold", data_out, 32'hE000_0003);
        out_ready = 1'b1;
        drive(4'b0001, 32'hDEAD_BEEF, 4'b0001);
        check("t5_full_pop", lane_full, 1);
        check("t5_no_overflow", overflow, 0);
        for (int k = 0; k < 4; k++) drive(4'b1110, 32'hF000_0000 + 32'(k << 8), 4'b1110);
        tick(20);
        check("t5_drained", pending(), 0);
        check("t5_last_word", data_out, 32'hDEAD_BEEF);
        check("t5_overflow_end", overflow, 0);

`ifdef UNSTRIPE_LANE_CNT_EN
        // Two active lanes; a change to four only lands at the next wrap.
        reset_L = 1'b0;
        active_lanes = 3'd2;
        clear_model();
        tick();
        reset_L = 1'b1;
        mlast = 1;
        for (int k = 0; k < 5; k++) drive(4'b1100, 32'h5000_0000 + 32'(k << 8), '0);
        check("t6_inactive_full", lane_full, 0);
        check("t6_inactive_overflow", overflow, 0);
        drive('1, 32'h6000_0000, 4'b0011);
        tick(4);
        check("t6_two_lane_drain", pending(), 0);
        active_lanes = 3'd4;
        drive(4'b1000, 32'h6100_0000, '0);
        drive(4'b0011, 32'h6200_0000, 4'b0011);
        tick(4);
        mlast = 3;
        drive('1, 32'h6300_0000, '1);
        tick(6);
        check("t6_four_lane_drain", pending(), 0);
        check("t6_idle", valid_out, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
